ctrl_pipe_hazard: RTL

// - Consumer end of the decoder control word: carries ID-stage control through the ID/EX, EX/MEM and MEM/WB stages.
// - Detects load-use hazards (stall plus EX bubble) and flushes on EX-resolved branch/jump redirects.
// - Generates EX-stage operand forwarding selects.
// - Sits between instruction decode and the datapath stage registers of the 5-stage core.

---
 rtl/ctrl_pipe_hazard_if.sv | 50 +++++
 rtl/ctrl_pipe_hazard.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder-to-pipeline control bus for ctrl_pipe_hazard. The counter signals exist only when HAZ_PERF_EN is defined.
interface ctrl_pipe_hazard_if #(
  parameter int CTRL_W = 11,
  parameter int REG_AW = 5
`ifdef HAZ_PERF_EN
  , parameter int CNT_W = 32
`endif
);
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              ex_redirect;
  logic              ex_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic              stall_if;
  logic              flush_ifid;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  modport master (
    output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_redirect,
    input  ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
    input  ex_rd, mem_rd, wb_rd, stall_if, flush_ifid, fwd_a, fwd_b
`ifdef HAZ_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_redirect,
    output ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
    output ex_rd, mem_rd, wb_rd, stall_if, flush_ifid, fwd_a, fwd_b
`ifdef HAZ_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Carries ID control through EX/MEM/WB, detects load-use stalls and redirect flushes, drives EX forwarding selects.
// Optional macro HAZ_PERF_EN adds stall/flush event counters.
module ctrl_pipe_hazard #(
  parameter int CTRL_W = 11,
  parameter int REG_AW = 5
`ifdef HAZ_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_pipe_hazard_if.slave  bus
);

  localparam int MEMREAD_B  = 6;
  localparam int REGWRITE_B = 8;

  logic              r_vld_p1, r_vld_p2, r_vld_p3;
  logic [CTRL_W-1:0] r_ctrl_p1, r_ctrl_p2, r_ctrl_p3;
  logic [REG_AW-1:0] r_rd_p1, r_rd_p2, r_rd_p3;
  logic [REG_AW-1:0] r_rs1_p1, r_rs2_p1;

  logic w_haz;
  logic w_bubble_ex;
  logic w_mem_wr;
  logic w_wb_wr;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              mem_wr,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_wr,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_wr && (mem_rd == rs))
      sel = 2'b10;
    else if (wb_wr && (wb_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // ID stage: hazard detection against the instruction currently in EX
  assign w_haz = bus.id_valid & r_vld_p1 & r_ctrl_p1[MEMREAD_B] & (r_rd_p1 != '0) &
                 ((r_rd_p1 == bus.id_rs1) | (r_rd_p1 == bus.id_rs2));
  assign bus.stall_if    = w_haz & ~bus.ex_redirect;
  assign bus.flush_ifid  = bus.ex_redirect;
  assign w_bubble_ex     = w_haz | bus.ex_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
      r_rd_p1   <= '0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_vld_p2  <= 1'b0;
      r_ctrl_p2 <= '0;
      r_rd_p2   <= '0;
      r_vld_p3  <= 1'b0;
      r_ctrl_p3 <= '0;
      r_rd_p3   <= '0;
    end else begin
      if (w_bubble_ex) begin
        r_vld_p1  <= 1'b0;
        r_ctrl_p1 <= '0;
        r_rd_p1   <= '0;
        r_rs1_p1  <= '0;
        r_rs2_p1  <= '0;
      end else begin
        r_vld_p1  <= bus.id_valid;
        r_ctrl_p1 <= bus.id_valid ? bus.id_ctrl : '0;
        r_rd_p1   <= bus.id_rd;
        r_rs1_p1  <= bus.id_rs1;
        r_rs2_p1  <= bus.id_rs2;
      end
      // EX -> MEM -> WB always advance
      r_vld_p2  <= r_vld_p1;
      r_ctrl_p2 <= r_ctrl_p1;
      r_rd_p2   <= r_rd_p1;
      r_vld_p3  <= r_vld_p2;
      r_ctrl_p3 <= r_ctrl_p2;
      r_rd_p3   <= r_rd_p2;
    end
  end

  // EX stage: operand forwarding from registered MEM/WB state
  assign w_mem_wr  = r_vld_p2 & r_ctrl_p2[REGWRITE_B] & (r_rd_p2 != '0);
  assign w_wb_wr   = r_vld_p3 & r_ctrl_p3[REGWRITE_B] & (r_rd_p3 != '0);
  assign bus.fwd_a = fwd_sel(r_rs1_p1, w_mem_wr, r_rd_p2, w_wb_wr, r_rd_p3);
  assign bus.fwd_b = fwd_sel(r_rs2_p1, w_mem_wr, r_rd_p2, w_wb_wr, r_rd_p3);

  assign bus.ex_valid  = r_vld_p1;
  assign bus.ex_ctrl   = r_ctrl_p1;
  assign bus.ex_rd     = r_rd_p1;
  assign bus.mem_valid = r_vld_p2;
  assign bus.mem_ctrl  = r_ctrl_p2;
  assign bus.mem_rd    = r_rd_p2;
  assign bus.wb_valid  = r_vld_p3;
  assign bus.wb_ctrl   = r_ctrl_p3;
  assign bus.wb_rd     = r_rd_p3;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(bus.stall_if);
      r_flush_cnt <= r_flush_cnt + CNT_W'(bus.flush_ifid);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule
